// File: rtl/itch_msg_sequencer.sv
// Front-end sequencer for the ITCH parser: loads a streamed message into seven
// holding registers and releases it for one cycle when the order book is free.
module itch_msg_sequencer #(
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_WIDTH-1:0] i_word,
    input  logic                 i_word_valid,
    input  logic                 i_word_last,
    output logic                 o_word_ready,
    input  logic                 i_book_busy,
    output logic [REG_WIDTH-1:0] o_reg_1,
    output logic [REG_WIDTH-1:0] o_reg_2,
    output logic [REG_WIDTH-1:0] o_reg_3,
    output logic [REG_WIDTH-1:0] o_reg_4,
    output logic [REG_WIDTH-1:0] o_reg_5,
    output logic [REG_WIDTH-1:0] o_reg_6,
    output logic [REG_WIDTH-1:0] o_reg_7,
    output logic                 o_parser_hold,
    output logic [CNT_WIDTH-1:0] o_msg_count,
    output logic [CNT_WIDTH-1:0] o_drop_count,
    output logic                 o_err_short
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t               state;
    logic [2:0]           index;
    logic [2:0]           exp_len;
    logic [2:0]           type_len;
    logic                 overlong;
    logic                 drop_pending;
    logic                 accept;
    logic [REG_WIDTH-1:0] regs [7];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        type_len = 3'd0;
        case (i_word[31:24])
            8'h41:   type_len = 3'd7;
            8'h58:   type_len = 3'd3;
            8'h45:   type_len = 3'd4;
            default: type_len = 3'd0;
        endcase
    end

    assign o_word_ready  = i_rst_n & (state != ST_ISSUE);
    assign o_parser_hold = (state != ST_ISSUE) | i_book_busy;
    assign accept        = i_word_valid & o_word_ready;

    assign o_reg_1 = regs[0];
    assign o_reg_2 = regs[1];
    assign o_reg_3 = regs[2];
    assign o_reg_4 = regs[3];
    assign o_reg_5 = regs[4];
    assign o_reg_6 = regs[5];
    assign o_reg_7 = regs[6];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            index        <= '0;
            exp_len      <= '0;
            overlong     <= 1'b0;
            drop_pending <= 1'b0;
            o_msg_count  <= '0;
            o_drop_count <= '0;
            o_err_short  <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) regs[i] <= '0;
        end else begin
            o_err_short <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    regs[0] <= i_word;
                    for (int unsigned i = 1; i < 7; i++) regs[i] <= '0;
                    if (type_len == 3'd0) begin
                        if (i_word_last) begin
                            o_drop_count <= sat_inc(o_drop_count);
                        end else begin
                            drop_pending <= 1'b1;
                            state        <= ST_DRAIN;
                        end
                    end else if (i_word_last) begin
                        o_err_short  <= 1'b1;
                        o_drop_count <= sat_inc(o_drop_count);
                    end else begin
                        index   <= 3'd1;
                        exp_len <= type_len;
                        state   <= ST_FILL;
                    end
                end
                ST_FILL: if (accept) begin
                    regs[index] <= i_word;
                    index       <= index + 3'd1;
                    if (index + 3'd1 == exp_len) begin
                        overlong <= ~i_word_last;
                        state    <= ST_ISSUE;
                    end else if (i_word_last) begin
                        o_err_short  <= 1'b1;
                        o_drop_count <= sat_inc(o_drop_count);
                        state        <= ST_IDLE;
                    end
                end
                ST_ISSUE: if (!i_book_busy) begin
                    o_msg_count <= sat_inc(o_msg_count);
                    index       <= '0;
                    state       <= overlong ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: if (accept && i_word_last) begin
                    // Only unknown-type messages are counted as drops here; overlong tails were already issued.
                    if (drop_pending) o_drop_count <= sat_inc(o_drop_count);
                    drop_pending <= 1'b0;
                    overlong     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itch_msg_sequencer.sv
// Randomised self-checking bench for itch_msg_sequencer, compared every cycle
// against a message-level model (word position within message, pending issue).
module tb_itch_msg_sequencer;

    localparam int RW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] i_word = '0;
    logic          i_word_valid = 1'b0;
    logic          i_word_last = 1'b0;
    logic          i_book_busy = 1'b0;
    logic          o_word_ready, o_parser_hold, o_err_short;
    logic [RW-1:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7;
    logic [CW-1:0] o_msg_count, o_drop_count;
    logic [RW-1:0] dregs [7];

    always #5 clk = ~clk;

    itch_msg_sequencer #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_word(i_word), .i_word_valid(i_word_valid),
        .i_word_last(i_word_last), .o_word_ready(o_word_ready), .i_book_busy(i_book_busy),
        .o_reg_1(o_reg_1), .o_reg_2(o_reg_2), .o_reg_3(o_reg_3), .o_reg_4(o_reg_4),
        .o_reg_5(o_reg_5), .o_reg_6(o_reg_6), .o_reg_7(o_reg_7),
        .o_parser_hold(o_parser_hold), .o_msg_count(o_msg_count),
        .o_drop_count(o_drop_count), .o_err_short(o_err_short)
    );

    assign dregs[0] = o_reg_1;
    assign dregs[1] = o_reg_2;
    assign dregs[2] = o_reg_3;
    assign dregs[3] = o_reg_4;
    assign dregs[4] = o_reg_5;
    assign dregs[5] = o_reg_6;
    assign dregs[6] = o_reg_7;

    typedef struct {
        logic [RW-1:0] w;
        logic          last;
    } beat_t;
    beat_t stream[$];

    int checks = 0;
    int errors = 0;

    // Model: position of the next word in the current message and whether an issue is owed.
    int            m_pos = 0;
    int            m_len = 0;
    bit            m_pend = 1'b0;
    bit            m_err = 1'b0;
    bit            acc_flag = 1'b0;
    logic [RW-1:0] m_regs [7] = '{default: '0};
    int            m_msg = 0;
    int            m_drop = 0;

    int            busy_mode = 0;
    int            gap_pct = 0;
    int            hold_low_cnt = 0;
    int            err_cnt = 0;
    logic [RW-1:0] snap_r1 = '0, snap_r4 = '0, snap_r7 = '0;

    function automatic int len_of(input logic [7:0] t);
        case (t)
            8'h41:   return 7;
            8'h58:   return 3;
            8'h45:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v == CMAX) ? v : v + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_len = 0; m_pend = 0; m_err = 0; acc_flag = 0;
            m_msg = 0; m_drop = 0;
            for (int k = 0; k < 7; k++) m_regs[k] = '0;
        end else begin
            m_err    = 0;
            acc_flag = 0;
            if (m_pend) begin
                if (!i_book_busy) begin
                    m_pend = 0;
                    m_msg  = sat(m_msg);
                end
            end else if (i_word_valid) begin
                acc_flag = 1;
                if (m_pos == 0) begin
                    m_len     = len_of(i_word[31:24]);
                    m_regs[0] = i_word;
                    for (int k = 1; k < 7; k++) m_regs[k] = '0;
                end else if (m_len != 0 && m_pos < m_len) begin
                    m_regs[m_pos] = i_word;
                end
                m_pos++;
                if (m_len != 0 && m_pos == m_len) m_pend = 1;
                if (i_word_last) begin
                    if (m_len == 0) m_drop = sat(m_drop);
                    else if (m_pos < m_len) begin
                        m_drop = sat(m_drop);
                        m_err  = 1;
                    end
                    m_pos = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready", o_word_ready, rst_n && !m_pend);
        check("hold", o_parser_hold, !(m_pend && !i_book_busy));
        check("err_short", o_err_short, m_err);
        check("msg_count", o_msg_count, m_msg);
        check("drop_count", o_drop_count, m_drop);
        for (int k = 0; k < 7; k++) check($sformatf("reg_%0d", k + 1), dregs[k], m_regs[k]);
        if (rst_n && !o_parser_hold) begin
            hold_low_cnt++;
            snap_r1 = o_reg_1;
            snap_r4 = o_reg_4;
            snap_r7 = o_reg_7;
        end
        if (o_err_short) err_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (acc_flag && stream.size() > 0) void'(stream.pop_front());
        case (busy_mode)
            0:       i_book_busy = 1'b0;
            1:       i_book_busy = 1'b1;
            default: i_book_busy = ($urandom_range(0, 99) < 40);
        endcase
        if (!rst_n || stream.size() == 0 || $urandom_range(0, 99) < gap_pct) begin
            i_word_valid = 1'b0;
            i_word       = $urandom;
            i_word_last  = 1'($urandom);
        end else begin
            i_word_valid = 1'b1;
            i_word       = stream[0].w;
            i_word_last  = stream[0].last;
        end
    end

    task automatic push_msg(input logic [7:0] t, input int n, input bit seq);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            if (k == 0) b.w = seq ? {t, 24'h1} : {t, 24'($urandom)};
            else        b.w = seq ? RW'(k + 1) : RW'($urandom);
            b.last = (k == n - 1);
            stream.push_back(b);
        end
    endtask

    task automatic push_rand();
        logic [7:0] t;
        int         l, n, r;
        r = $urandom_range(0, 99);
        if (r < 20) begin
            do t = 8'($urandom); while (len_of(t) != 0);
            n = $urandom_range(1, 5);
        end else begin
            case ($urandom_range(0, 2))
                0:       t = 8'h41;
                1:       t = 8'h58;
                default: t = 8'h45;
            endcase
            l = len_of(t);
            r = $urandom_range(0, 99);
            if (r < 55)      n = l;
            else if (r < 75) n = $urandom_range(1, l - 1);
            else             n = l + $urandom_range(1, 3);
        end
        push_msg(t, n, 1'b0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (stream.size() == 0 && !m_pend && !i_word_valid) begin
                repeat (2) @(posedge clk);
                #2;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=busy expected=idle", name);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", o_word_ready, 0);
        check("rst_hold", o_parser_hold, 1);
        check("rst_msg", o_msg_count, 0);
        rst_n = 1'b1;

        // Plain add, book idle
        hold_low_cnt = 0;
        push_msg(8'h41, 7, 1'b1);
        wait_idle(200, "add_idle");
        check("add_issue_cycles", hold_low_cnt, 1);
        check("add_reg1", snap_r1, 32'h41000001);
        check("add_reg7", snap_r7, 32'h00000007);
        check("add_msg", o_msg_count, 1);

        // Add held off by a busy book
        busy_mode = 1;
        hold_low_cnt = 0;
        push_msg(8'h41, 7, 1'b1);
        for (int i = 0; i < 200 && !m_pend; i++) begin
            @(posedge clk);
            #2;
        end
        check("busy_reached_issue", m_pend, 1);
        for (int i = 0; i < 5; i++) begin
            check("busy_ready", o_word_ready, 0);
            check("busy_hold", o_parser_hold, 1);
            if (i < 4) begin
                @(posedge clk);
                #2;
            end
        end
        busy_mode = 0;
        wait_idle(200, "add_busy");
        check("busy_issue_cycles", hold_low_cnt, 1);
        check("busy_msg", o_msg_count, 2);

        // Short cancel, then a good cancel
        hold_low_cnt = 0;
        err_cnt = 0;
        push_msg(8'h58, 2, 1'b1);
        push_msg(8'h58, 3, 1'b1);
        wait_idle(200, "cancel");
        check("cancel_err_pulses", err_cnt, 1);
        check("cancel_drop", o_drop_count, 1);
        check("cancel_msg", o_msg_count, 3);
        check("cancel_issue_cycles", hold_low_cnt, 1);
        check("cancel_reg4", snap_r4, 0);

        // Unknown type then execute
        hold_low_cnt = 0;
        push_msg(8'h5A, 4, 1'b1);
        push_msg(8'h45, 4, 1'b1);
        wait_idle(200, "unknown_exec");
        check("unk_drop", o_drop_count, 2);
        check("unk_msg", o_msg_count, 4);
        check("unk_issue_cycles", hold_low_cnt, 1);

        // Overlong execute drains its tail, then an add follows
        push_msg(8'h45, 6, 1'b1);
        push_msg(8'h41, 7, 1'b1);
        wait_idle(200, "overlong");
        check("long_drop", o_drop_count, 2);
        check("long_msg", o_msg_count, 6);
        check("long_reg7", snap_r7, 32'h00000007);

        // Reset in the middle of an add
        push_msg(8'h41, 7, 1'b1);
        for (int i = 0; i < 200 && m_pos != 3; i++) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        stream.delete();
        #1;
        check("midrst_ready", o_word_ready, 0);
        check("midrst_hold", o_parser_hold, 1);
        check("midrst_msg", o_msg_count, 0);
        check("midrst_drop", o_drop_count, 0);
        check("midrst_reg1", o_reg_1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_msg(8'h41, 7, 1'b1);
        wait_idle(200, "after_reset");
        check("afterrst_msg", o_msg_count, 1);
        check("afterrst_reg1", snap_r1, 32'h41000001);

        // Random traffic with gaps and a flaky book; counters saturate
        busy_mode = 2;
        gap_pct = 25;
        for (int i = 0; i < 250; i++) push_rand();
        wait_idle(30000, "random");
        check("sat_msg", o_msg_count, CMAX);
        check("sat_drop", o_drop_count, CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/itch_msg_sequencer.md
# itch_msg_sequencer

Front-end controller for the ITCH `parser`. It accepts the incoming ITCH message as a stream of 32-bit words with a valid/ready handshake and loads the words into seven holding registers that drive the parser's `i_reg_1`..`i_reg_7`. It then releases the message to the parser for exactly one cycle, and only when the order book is not busy. Malformed, truncated and unknown messages are dropped without reaching the parser.

## Interface
- `REG_WIDTH`, 32: word width; must match the parser's `REG_WIDTH`.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_word`  in  REG_WIDTH: stream word; the first word carries the message type in [31:24].
- `i_word_valid`  in  1: `i_word` is valid.
- `i_word_last`  in  1: final word of the message; qualified by `i_word_valid`.
- `o_word_ready`  out  1: the block accepts a word this cycle.
- `i_book_busy`  in  1: the order book cannot take a new order.
- `o_reg_1`..`o_reg_7`  out  REG_WIDTH each: holding registers; connect to parser `i_reg_1`..`i_reg_7`.
- `o_parser_hold`  out  1: connect to parser `i_book_is_busy`; 0 = parser samples this cycle.
- `o_msg_count`  out  CNT_WIDTH: number of messages issued; saturates at all-ones.
- `o_drop_count`  out  CNT_WIDTH: number of messages dropped; saturates at all-ones.
- `o_err_short`  out  1: one-cycle pulse when `i_word_last` arrives before the expected length.

## Operation
- A word is accepted when `i_word_valid & o_word_ready`. At most one word is accepted per cycle.
- Expected length is decoded from the first word's [31:24]:
  - 0x41 (add): 7 words.
  - 0x58 (cancel): 3 words.
  - 0x45 (execute): 4 words.
  - Any other value: unknown.
- States:
  - IDLE: `o_word_ready`=1. On accept, write `o_reg_1`=`i_word` and clear `o_reg_2`..`o_reg_7` to 0. Then:
    - Unknown type with `last`: increment drop, stay in IDLE.
    - Unknown type without `last`: go to DRAIN; increment drop when the message's `last` arrives.
    - Known type with `last`: pulse `o_err_short`, increment drop, stay in IDLE.
    - Known type without `last`: set the index to 1, go to FILL.
  - FILL: `o_word_ready`=1. The accepted word is written to `o_reg_(index+1)` and the index increments.
    - `last` on a word before the final expected word: pulse `o_err_short`, increment drop, go to IDLE.
    - Final expected word accepted: go to ISSUE. If that word lacks `last`, set the overlong flag.
  - ISSUE: `o_word_ready`=0; the registers are frozen.
    - `o_parser_hold` = `i_book_busy` (combinational). It is therefore 0 in the first ISSUE cycle in which `i_book_busy`=0.
    - In that cycle, increment msg and go to DRAIN if the overlong flag is set, else to IDLE.
    - ISSUE has no timeout; it waits indefinitely for the book.
  - DRAIN: `o_word_ready`=1; accepted words are discarded. On `last`, go to IDLE and clear the overlong flag. DRAIN entered after an issue does not increment drop.
- `o_parser_hold`=1 in every state other than ISSUE. The parser therefore never samples partially loaded registers.
- Counters saturate: an increment at all-ones leaves the counter unchanged.
- `o_reg_*` change only on accepted words in IDLE or FILL.

## Timing
- Reset (asynchronous, while `i_rst_n`=0):
  - state = IDLE, index = 0, overlong flag = 0.
  - `o_reg_*` = 0, both counters = 0, `o_err_short` = 0, `o_parser_hold` = 1.
  - `o_word_ready` is forced to 0 while reset is asserted; it is 1 in the first cycle after deassertion.
- Reset asserted mid-message or during ISSUE discards the message; no issue occurs and no count is recorded.
- Add message, back-to-back words, book idle:
  - Beats in cycles 0..6, ISSUE in cycle 7 with `o_parser_hold`=0.
  - The parser captures at the end of cycle 7; parser `o_valid` is high in cycle 8.
  - The next message's first word is accepted in cycle 8.
- Minimum message period is therefore length+1 cycles.
- `o_err_short` is registered and high for the single cycle after the offending beat. Counter updates are visible in that same cycle.
- A stalled stream (`i_word_valid`=0) holds state and index; there is no timeout.

## Test plan
- Stream words 0x41000001, 0x00000002 .. 0x00000007 with `last` on word 7, `i_book_busy`=0:
  - `o_parser_hold`=0 for exactly one cycle, one cycle after word 7.
  - `o_reg_1`=0x41000001 and `o_reg_7`=0x00000007 during that cycle.
  - `o_msg_count`=1.
- Same add message with `i_book_busy`=1 for 5 cycles after the final word:
  - `o_word_ready`=0 and `o_parser_hold`=1 for 5 cycles.
  - Issue occurs in the 6th cycle; the registers are unchanged throughout.
- Cancel 0x58xxxxxx with `last` on word 2:
  - `o_err_short` pulses once, `o_drop_count`=1, `o_parser_hold` never 0.
  - A following valid 3-word cancel issues with `o_reg_4`..`o_reg_7`=0.
- Unknown type 0x5A with 4 words, then an execute (0x45, 4 words):
  - Drop counted on the 4th word, with no issue.
  - The execute issues, giving `o_msg_count`=1 and `o_drop_count`=1.
- Execute sent as 6 words with `last` on word 6:
  - Issue occurs after word 4; words 5 and 6 are drained.
  - The next message starts loading cleanly and `o_drop_count` stays 0.
- Assert `i_rst_n`=0 after 3 words of an add:
  - All outputs go to their reset values immediately and `o_word_ready`=0 while in reset.
  - After release, a complete add issues normally.
